// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - seconds countdown timer driven by the divider's one_hz_enable strobe
module countdown_timer #(
    parameter int VALUE_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start_timer,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   pause,
    input  logic                   one_hz_enable,
    output logic                   divider_restart,
    output logic                   expired,
    output logic                   busy,
    output logic [VALUE_WIDTH-1:0] time_left
);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t                 state_q;
    logic [VALUE_WIDTH-1:0] time_left_q;
    logic [VALUE_WIDTH-1:0] time_left_d;
    logic                   busy_q;
    logic                   expired_q;
    logic                   divider_restart_q;
    logic                   accept_strobe;

    assign accept_strobe = (state_q == COUNT) && one_hz_enable && !pause;
    assign time_left_d   = time_left_q - {{(VALUE_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= IDLE;
            time_left_q       <= '0;
            busy_q            <= 1'b0;
            expired_q         <= 1'b0;
            divider_restart_q <= 1'b0;
        end else begin
            expired_q         <= 1'b0;
            divider_restart_q <= 1'b0;
            if (start_timer) begin
                // A start swallows any strobe in the same cycle and re-phases the divider.
                time_left_q       <= value;
                divider_restart_q <= 1'b1;
                if (value != '0) begin
                    state_q <= COUNT;
                    busy_q  <= 1'b1;
                end else begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    expired_q <= 1'b1;
                end
            end else if (accept_strobe) begin
                if (time_left_q > {{(VALUE_WIDTH-1){1'b0}}, 1'b1}) begin
                    time_left_q <= time_left_d;
                end else begin
                    time_left_q <= '0;
                    expired_q   <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            end
        end
    end

    assign time_left       = time_left_q;
    assign busy            = busy_q;
    assign expired         = expired_q;
    assign divider_restart = divider_restart_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed and randomized bench for countdown_timer
module tb_countdown_timer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_timer = 1'b0;
    logic [3:0] value = 4'd0;
    logic       pause = 1'b0;
    logic       one_hz_enable = 1'b0;
    logic       divider_restart;
    logic       expired;
    logic       busy;
    logic [3:0] time_left;

    int errors = 0;
    int checks = 0;

    countdown_timer #(.VALUE_WIDTH(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .start_timer    (start_timer),
        .value          (value),
        .pause          (pause),
        .one_hz_enable  (one_hz_enable),
        .divider_restart(divider_restart),
        .expired        (expired),
        .busy           (busy),
        .time_left      (time_left)
    );

    always #5 clock = ~clock;

    // Reference: seconds remaining as a plain integer plus a running flag.
    int remaining = 0;
    bit running = 0;
    bit m_expired = 0;
    bit m_restart = 0;
    bit model_valid = 0;

    always @(posedge clock) begin
        if (reset) begin
            remaining = 0;
            running   = 0;
            m_expired = 0;
            m_restart = 0;
            model_valid = 1;
        end else begin
            m_expired = 0;
            m_restart = start_timer;
            if (start_timer) begin
                remaining = int'(value);
                running   = (remaining > 0);
                m_expired = (remaining == 0);
            end else if (running && one_hz_enable && !pause) begin
                remaining = remaining - 1;
                if (remaining == 0) begin
                    running   = 0;
                    m_expired = 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (model_valid) begin
            check("model_time_left", 32'(time_left), 32'(remaining));
            check("model_busy", 32'(busy), 32'(running));
            check("model_expired", 32'(expired), 32'(m_expired));
            check("model_restart", 32'(divider_restart), 32'(m_restart));
        end
    end

    task automatic step(input logic st, input logic [3:0] v, input logic p,
                        input logic s, input logic r);
        start_timer   = st;
        value         = v;
        pause         = p;
        one_hz_enable = s;
        reset         = r;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0, 0);
    endtask

    task automatic strobe(input logic p);
        step(0, 4'd0, p, 1, 0);
    endtask

    initial begin
        // 1: reset
        step(0, 4'd0, 0, 0, 1);
        step(0, 4'd0, 0, 0, 1);
        check("rst_time_left", 32'(time_left), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_expired", 32'(expired), 0);
        check("rst_restart", 32'(divider_restart), 0);

        // 2: value=3, strobe every 10 cycles
        step(1, 4'd3, 0, 0, 0);
        check("s2_restart", 32'(divider_restart), 1);
        check("s2_load", 32'(time_left), 3);
        check("s2_busy", 32'(busy), 1);
        for (int k = 1; k <= 3; k++) begin
            idle(9);
            if (k == 1) check("s2_restart_clear", 32'(divider_restart), 0);
            strobe(0);
            check("s2_time_left", 32'(time_left), 32'(3 - k));
            check("s2_expired", 32'(expired), (k == 3) ? 1 : 0);
            check("s2_busy_run", 32'(busy), (k == 3) ? 0 : 1);
        end
        idle(1);
        check("s2_expired_one_cycle", 32'(expired), 0);

        // 3: value=0 expires immediately
        step(1, 4'd0, 0, 1, 0);
        check("s3_expired", 32'(expired), 1);
        check("s3_busy", 32'(busy), 0);
        check("s3_time_left", 32'(time_left), 0);
        idle(1);
        check("s3_expired_drop", 32'(expired), 0);

        // 4: pause masks two strobes
        step(1, 4'd5, 0, 0, 0);
        strobe(0);
        check("s4_first", 32'(time_left), 4);
        strobe(1);
        idle(2);
        strobe(1);
        check("s4_hold", 32'(time_left), 4);
        check("s4_busy_hold", 32'(busy), 1);
        for (int k = 1; k <= 4; k++) begin
            idle(2);
            strobe(0);
            check("s4_expired", 32'(expired), (k == 4) ? 1 : 0);
        end

        // 5: restart mid-count with a coincident strobe
        step(1, 4'd4, 0, 0, 0);
        strobe(0);
        strobe(0);
        check("s5_mid", 32'(time_left), 2);
        step(1, 4'd2, 0, 1, 0);
        check("s5_reload", 32'(time_left), 2);
        check("s5_no_expired", 32'(expired), 0);
        strobe(0);
        check("s5_one", 32'(time_left), 1);
        strobe(0);
        check("s5_expired", 32'(expired), 1);

        // 6: reset aborts at 7
        step(1, 4'd15, 0, 0, 0);
        for (int k = 0; k < 8; k++) strobe(0);
        check("s6_seven", 32'(time_left), 7);
        step(0, 4'd0, 0, 1, 1);
        check("s6_rst_time", 32'(time_left), 0);
        check("s6_rst_busy", 32'(busy), 0);
        check("s6_rst_expired", 32'(expired), 0);
        strobe(0);
        strobe(0);
        check("s6_ignored", 32'(time_left), 0);
        check("s6_no_expired", 32'(expired), 0);

        // full range and held start
        step(1, 4'd15, 0, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            strobe(0);
            check("full_expired", 32'(expired), (k == 15) ? 1 : 0);
        end
        for (int k = 0; k < 3; k++) begin
            step(1, 4'd9, 0, 1, 0);
            check("held_restart", 32'(divider_restart), 1);
            check("held_value", 32'(time_left), 9);
        end

        // randomized traffic, checked against the reference every cycle
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 15) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 199) == 0));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
